// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_subtractor_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a requester (master) and the subtractor (slave).
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the slave reports idle.
// Signals: start/a/b driven by master; busy/done/diff/borrow_out/overflow by slave.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow into the next bit.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b, bin in; d, bout out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per cycle; reports diff, borrow and signed overflow.
// Latency: WIDTH cycles from accepting edge to done; done pulses for one cycle.
// Backpressure: start is sampled only in IDLE; requests in RUN/DONE are dropped.
// Ports: clk, rst_n (async, active-low), bus (slave modport of serial_subtractor_if).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             bin_q;
    logic [CW-1:0]    cnt;
    // Operand sign bits kept aside because the shift registers lose them.
    logic             a_msb;
    logic             b_msb;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    logic             d_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {d_bit, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            bin_q    <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
                        bin_q  <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= res_next;
                    bin_q <= bout_bit;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // d_bit here is the result MSB.
                        diff_q   <= res_next;
                        borrow_q <= bout_bit;
                        ovf_q    <= (a_msb != b_msb) && (d_bit != a_msb);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of the bit-serial subtractor at WIDTH=8.
// Latency: checks done WIDTH cycles after accept and W+2 spacing back-to-back.
// Backpressure: exercises start while busy and reset mid-operation.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   done_cyc;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from IDLE and check latency, stability and results.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [7:0] ed, input logic eb, input logic eo);
        logic [7:0] held;
        int k;
        held     = bus.diff;
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = ~ia;
        bus.b     = ~ib;
        check({tag, " busy_after_accept"}, {31'd0, bus.busy}, 32'd1);
        k = 0;
        while (!bus.done && k < 4 * W) begin
            check({tag, " diff_stable_run"}, {24'd0, bus.diff}, {24'd0, held});
            @(posedge clk); #1;
            k++;
        end
        done_cyc = cyc;
        check({tag, " latency"}, k, W);
        check({tag, " diff"}, {24'd0, bus.diff}, {24'd0, ed});
        check({tag, " borrow"}, {31'd0, bus.borrow_out}, {31'd0, eb});
        check({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, eo});
        check({tag, " busy_in_done"}, {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int first_done;
        logic [7:0] ra, rb, md;
        logic mb, mo;

        checks    = 0;
        errors    = 0;
        done_cyc  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        #3;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset diff", {24'd0, bus.diff}, 32'd0);
        check("reset borrow", {31'd0, bus.borrow_out}, 32'd0);
        check("reset overflow", {31'd0, bus.overflow}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First start accepted on the first rising edge after reset release
        run_op("basic_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("under_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("ovf_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        // Start while busy: second request in cycle 3 must be dropped
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        ndone     = 0;
        @(posedge clk); #1;
        for (int c = 1; c <= 3 * W; c++) begin
            if (c == 2) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.b     = 8'h00;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("busy_start done_count", ndone, 1);
        check("busy_start diff", {24'd0, bus.diff}, 32'h0F);
        check("busy_start borrow", {31'd0, bus.borrow_out}, 32'd0);
        check("busy_start overflow", {31'd0, bus.overflow}, 32'd0);

        run_op("ovf_7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Reset during RUN cycle 4
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        check("midrst diff", {24'd0, bus.diff}, 32'd0);
        check("midrst borrow", {31'd0, bus.borrow_out}, 32'd0);
        check("midrst overflow", {31'd0, bus.overflow}, 32'd0);
        ndone = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * W; c++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("midrst no_done", ndone, 0);
        check("midrst diff_after", {24'd0, bus.diff}, 32'd0);
        run_op("post_rst_09_09", 8'h09, 8'h09, 8'h00, 1'b0, 1'b0);

        // Back-to-back: start in the IDLE cycle right after DONE
        run_op("b2b_first", 8'h20, 8'h08, 8'h18, 1'b0, 1'b0);
        first_done = done_cyc;
        run_op("b2b_second", 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0);
        check("b2b spacing", done_cyc - first_done, W + 2);

        // Random sweep against a behavioural model of a-b
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            md = ra - rb;
            mb = (ra < rb);
            mo = (ra[7] != rb[7]) && (md[7] != ra[7]);
            run_op($sformatf("sweep%0d_%02h_%02h", i, ra, rb), ra, rb, md, mb, mo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH SHALL default to 8; it sets the operand width in bits, with a legal range of 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous and active-low.
REQ-004 start  input  1  SHALL request an operation; it is sampled only in IDLE.
REQ-005 a  input  WIDTH  SHALL be the minuend, captured on the accepting edge.
REQ-006 b  input  WIDTH  SHALL be the subtrahend, captured on the accepting edge.
REQ-007 busy  output  1  SHALL be high while in RUN.
REQ-008 done  output  1  SHALL be a one-cycle pulse, high exactly while in DONE.
REQ-009 diff  output  WIDTH  SHALL be the result a-b mod 2^WIDTH, held until the next completion.
REQ-010 borrow_out  output  1  SHALL be the final borrow: 1 iff unsigned a<b.
REQ-011 overflow  output  1  SHALL be the two's-complement overflow of a-b.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 on an edge, the block SHALL latch a and b into shift registers, clear the borrow flop and the bit counter, and go to RUN.
REQ-014 Each RUN edge SHALL process one bit, LSB first: d = a0^b0^bin and bout = (~a0&b0) | (~(a0^b0)&bin). It then shifts d into the result register MSB-side, stores bout and increments the counter.
REQ-015 The edge that processes bit WIDTH-1 SHALL update diff, borrow_out and overflow together and go to DONE.
REQ-016 Overflow SHALL be computed as (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the latched operands.
REQ-017 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge N, busy SHALL be high from N to N+WIDTH and done SHALL be high from N+WIDTH to N+WIDTH+1.
REQ-019 start SHALL be ignored in RUN and DONE, with no queuing and no effect on the operation in progress.
REQ-020 Back-to-back: start high in the cycle after DONE (IDLE) SHALL be accepted, giving one idle cycle between done pulses.
REQ-021 diff, borrow_out and overflow SHALL change only on the completing edge and stay stable in IDLE and RUN.
REQ-022 Changes to a and b after the accepting edge SHALL have no effect on the result.
REQ-023 The counter SHALL be $clog2(WIDTH)+1 bits wide, with no wrap-around within one operation.

Reset
REQ-024 When rst_n is low, the block SHALL immediately force IDLE, busy=0, done=0, diff=0, borrow_out=0, overflow=0, counter=0 and borrow flop=0.
REQ-025 Reset asserted mid-operation SHALL abort it with no done pulse; the partial result SHALL be discarded.
REQ-026 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-027 The package serial_subtractor_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-028 The per-bit arithmetic SHALL live in the combinational sub-module full_subtractor (a, b, bin -> d, bout), instantiated once.
REQ-029 The block SHALL contain no latches and no combinational path from start to any output.

Verification
REQ-030 Basic subtraction: a=0x05, b=0x03, start 1 cycle -> done 8 cycles later; diff=0x02, borrow_out=0, overflow=0.
REQ-031 Unsigned underflow: a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0.
REQ-032 Signed overflow: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
REQ-033 Start while busy: start=1 with a=0x10, b=0x01, then a second start in cycle 3 with a=0xFF, b=0x00 -> exactly one done, diff=0x0F.
REQ-034 Reset mid-operation: rst_n low at RUN cycle 4 -> outputs zero immediately, no done; a new 0x09-0x09 operation afterwards -> diff=0x00, borrow_out=0.
REQ-035 Back-to-back and sweep: start again in the IDLE cycle after done -> second done WIDTH+2 cycles after the first; run random operand sweeps against a reference model of a-b.
